// File: rtl/hash_writer_pkg.sv
// Shared types and address helper for the HASH RAM write-side producer.
package hash_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam int WORD_BYTES = 8;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  // Byte address of word idx in bank; caller truncates to the RAM address width.
  function automatic logic [63:0] word_byte_addr(input logic [63:0] base,
                                                 input logic        bank,
                                                 input logic [15:0] idx,
                                                 input int          depth);
    logic [63:0] word;
    word = (bank ? 64'(depth) : 64'd0) + {48'd0, idx};
    return base + word * 64'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/hash_bank_tracker.sv
// Readable-bank bookkeeping: two-bank ring under HASH_WRITER_PINGPONG_EN, else one flag.
// A commit becomes visible on hash_ready the cycle after it is presented.
module hash_bank_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic commit,
  input  logic consume_done,
  output logic hash_ready,
  output logic rd_bank,
  output logic wr_bank,
  output logic full
);

`ifdef HASH_WRITER_PINGPONG_EN
  logic [1:0] cnt_q, cnt_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       rel;

  always_comb begin
    rel   = consume_done && (cnt_q != 2'd0);
    cnt_d = cnt_q + {1'b0, commit} - {1'b0, rel};
    rd_d  = rd_q ^ rel;
    wr_d  = wr_q ^ commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

  // A commit still in flight counts, so a new fill never lands on a readable bank.
  assign full       = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && commit);
  assign hash_ready = (cnt_q != 2'd0);
  assign rd_bank    = rd_q;
  assign wr_bank    = wr_q;
`else
  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (commit) begin
      flag_d = 1'b1;
    end else if (consume_done) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign full       = flag_q || commit;
  assign hash_ready = flag_q;
  assign rd_bank    = 1'b0;
  assign wr_bank    = 1'b0;
`endif

endmodule

// File: rtl/hash_bram_writer.sv
// Writes a valid/ready stream of 64-bit words into the HASH RAM and publishes complete blocks.
// Optional two-bank ping-pong buffering under HASH_WRITER_PINGPONG_EN.
module hash_bram_writer
  import hash_writer_pkg::*;
#(
  parameter int                DEPTH_WORDS = 64,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       blk_len,
  input  logic              s_valid,
  input  logic [63:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] waddr,
  output logic [63:0]       wdata,
  output logic [7:0]        wmask,
  output logic              wen,
  output logic              HASH_ready,
  output logic              rd_bank,
  input  logic              consume_done,
  output logic              busy,
  output logic              len_err
);

  localparam logic [15:0] DEPTH_LEN = 16'(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              len_err_q, len_err_d;
  logic              commit_q, commit_d;

  beat_t beat;
  logic  hs;
  logic  bank_full;
  logic  wr_bank;
  logic  hash_ready_w;

  assign beat = '{data: s_data, last: s_last};
  assign hs   = s_valid && s_ready;

  hash_bank_tracker u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit       (commit_q),
    .consume_done (consume_done),
    .hash_ready   (hash_ready_w),
    .rd_bank      (rd_bank),
    .wr_bank      (wr_bank),
    .full         (bank_full)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    len_err_d = len_err_q;
    commit_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !bank_full) begin
          if ((blk_len == 16'd0) || (blk_len > DEPTH_LEN)) begin
            len_err_d = 1'b1;
          end else begin
            len_d   = blk_len;
            cnt_d   = 16'd0;
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (hs) begin
          wen_d   = 1'b1;
          wdata_d = beat.data;
          waddr_d = ADDR_W'(word_byte_addr(64'(BASE_ADDR), wr_bank, cnt_q, DEPTH_WORDS));
          cnt_d   = cnt_q + 16'd1;
          if ((cnt_d == len_q) || beat.last) begin
            // Commit is delayed a cycle so the final word is in the RAM before publishing.
            commit_d = 1'b1;
            if (cnt_d != len_q) begin
              len_err_d = 1'b1;
            end
`ifdef HASH_WRITER_PINGPONG_EN
            state_d = ST_IDLE;
`else
            state_d = ST_READY;
`endif
          end
        end
      end

      ST_READY: begin
        if (consume_done && hash_ready_w) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= 16'd0;
      cnt_q     <= 16'd0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= 64'd0;
      len_err_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      len_err_q <= len_err_d;
      commit_q  <= commit_d;
    end
  end

  assign s_ready    = (state_q == ST_FILL);
  assign busy       = (state_q == ST_FILL);
  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign wmask      = wen_q ? 8'hFF : 8'h00;
  assign len_err    = len_err_q;
  assign HASH_ready = hash_ready_w;

endmodule

// File: tb/tb_hash_bram_writer.sv
// Scoreboard bench for hash_bram_writer: expected RAM writes are queued as words are handed over.
module tb_hash_bram_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] blk_len;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic [31:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        wen;
  logic        HASH_ready;
  logic        rd_bank;
  logic        consume_done;
  logic        busy;
  logic        len_err;

  hash_bram_writer #(
    .DEPTH_WORDS (64),
    .ADDR_W      (32),
    .BASE_ADDR   (32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .blk_len      (blk_len),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .waddr        (waddr),
    .wdata        (wdata),
    .wmask        (wmask),
    .wen          (wen),
    .HASH_ready   (HASH_ready),
    .rd_bank      (rd_bank),
    .consume_done (consume_done),
    .busy         (busy),
    .len_err      (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t sbq[$];
  int  total = 0;
  int  bad   = 0;
  int  wb    = 0;
  int  idx   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int b, input int i);
    return 32'(8 * (b * 64 + i));
  endfunction

  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n) begin
      if (wen) begin
        if (sbq.size() == 0) begin
          chk("unexp_wr", {63'd0, wen}, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("waddr", {32'd0, waddr}, {32'd0, e.addr});
          chk("wdata", wdata, e.data);
          chk("wmask", {56'd0, wmask}, 64'hFF);
        end
      end else begin
        chk("wmask_idle", {56'd0, wmask}, 64'h00);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    blk_len = 16'(len);
    cycle();
    start = 1'b0;
    idx   = 0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic last);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 20) begin
      cycle();
      n++;
    end
    if (!s_ready) begin
      chk("hs_timeout", {63'd0, s_ready}, 64'd1);
    end else begin
      sbq.push_back('{exp_addr(wb, idx), d});
      idx++;
    end
    cycle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Mirrors the design's write-bank pointer toggle on each completed block.
  task automatic block_done();
`ifdef HASH_WRITER_PINGPONG_EN
    wb = wb ^ 1;
`endif
  endtask

  task automatic consume();
    consume_done = 1'b1;
    cycle();
    consume_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    wb    = 0;
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    blk_len      = 16'd0;
    s_valid      = 1'b0;
    s_data       = 64'd0;
    s_last       = 1'b0;
    consume_done = 1'b0;
    cycle();
    cycle();
    chk("rst_wen", {63'd0, wen}, 64'd0);
    chk("rst_hr", {63'd0, HASH_ready}, 64'd0);
    chk("rst_srdy", {63'd0, s_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_lerr", {63'd0, len_err}, 64'd0);
    chk("rst_rdbank", {63'd0, rd_bank}, 64'd0);
    rst_n = 1'b1;
    cycle();

    // Back-to-back block of four, no s_last; an extra word must be refused.
    do_start(4);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    send_word(64'h11, 1'b0);
    send_word(64'h22, 1'b0);
    send_word(64'h33, 1'b0);
    send_word(64'h44, 1'b0);
    block_done();
    chk("t1_hr_early", {63'd0, HASH_ready}, 64'd0);
    chk("t1_srdy_off", {63'd0, s_ready}, 64'd0);
    s_valid = 1'b1;
    s_data  = 64'h55;
    cycle();
    s_valid = 1'b0;
    chk("t1_hr", {63'd0, HASH_ready}, 64'd1);
    chk("t1_lerr", {63'd0, len_err}, 64'd0);
    consume();
    chk("t1_hr_rel", {63'd0, HASH_ready}, 64'd0);
    chk("t1_idle", {63'd0, busy}, 64'd0);

    // Gapped stream of three words.
    do_start(3);
    send_word(64'hA1, 1'b0);
    cycle();
    send_word(64'hA2, 1'b0);
    cycle();
    send_word(64'hA3, 1'b1);
    block_done();
    chk("t2_hr_early", {63'd0, HASH_ready}, 64'd0);
    cycle();
    chk("t2_hr", {63'd0, HASH_ready}, 64'd1);
`ifndef HASH_WRITER_PINGPONG_EN
    start   = 1'b1;
    blk_len = 16'd2;
`endif
    consume();
    start = 1'b0;
    chk("t2_hr_rel", {63'd0, HASH_ready}, 64'd0);
    chk("t2_idle", {63'd0, busy}, 64'd0);
    cycle();
    chk("t2_start_ign", {63'd0, busy}, 64'd0);

    // Reset in the middle of a fill.
    do_start(8);
    send_word(64'hB1, 1'b0);
    send_word(64'hB2, 1'b0);
    cycle();
    s_valid = 1'b1;
    s_data  = 64'hB3;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wen", {63'd0, wen}, 64'd0);
    chk("rst_mid_hr", {63'd0, HASH_ready}, 64'd0);
    chk("rst_mid_srdy", {63'd0, s_ready}, 64'd0);
    s_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    wb    = 0;
    cycle();
    chk("rst_mid_sb", 64'(sbq.size()), 64'd0);
    do_start(2);
    send_word(64'hC1, 1'b0);
    send_word(64'hC2, 1'b1);
    block_done();
    cycle();
    chk("rst_new_hr", {63'd0, HASH_ready}, 64'd1);
    consume();

    // Illegal lengths.
    do_start(0);
    cycle();
    cycle();
    chk("len0_err", {63'd0, len_err}, 64'd1);
    chk("len0_idle", {63'd0, busy}, 64'd0);
    do_reset();
    chk("len_err_clr", {63'd0, len_err}, 64'd0);
    do_start(65);
    cycle();
    cycle();
    chk("len65_err", {63'd0, len_err}, 64'd1);
    chk("len65_srdy", {63'd0, s_ready}, 64'd0);
    do_reset();

    // Full-depth block is legal.
    do_start(64);
    for (int i = 0; i < 64; i++) begin
      send_word(64'h1000 + 64'(i), (i == 63));
    end
    block_done();
    cycle();
    chk("len64_hr", {63'd0, HASH_ready}, 64'd1);
    chk("len64_err", {63'd0, len_err}, 64'd0);
    consume();

    // Early s_last.
    do_start(5);
    send_word(64'hD1, 1'b0);
    send_word(64'hD2, 1'b1);
    block_done();
    chk("early_srdy", {63'd0, s_ready}, 64'd0);
    cycle();
    chk("early_hr", {63'd0, HASH_ready}, 64'd1);
    chk("early_err", {63'd0, len_err}, 64'd1);
`ifndef HASH_WRITER_PINGPONG_EN
    do_start(3);
    chk("ready_start_ign", {63'd0, busy}, 64'd0);
    chk("rdbank_const", {63'd0, rd_bank}, 64'd0);
`endif
    consume();
    chk("early_rel", {63'd0, HASH_ready}, 64'd0);
    do_reset();

`ifdef HASH_WRITER_PINGPONG_EN
    do_start(2);
    send_word(64'hE1, 1'b0);
    send_word(64'hE2, 1'b1);
    block_done();
    cycle();
    chk("pp_hr0", {63'd0, HASH_ready}, 64'd1);
    chk("pp_rd0", {63'd0, rd_bank}, 64'd0);
    do_start(2);
    send_word(64'hF1, 1'b0);
    send_word(64'hF2, 1'b1);
    block_done();
    cycle();
    cycle();
    do_start(2);
    chk("pp_full_ign", {63'd0, busy}, 64'd0);
    s_valid = 1'b1;
    s_data  = 64'hF3;
    cycle();
    cycle();
    chk("pp_full_srdy", {63'd0, s_ready}, 64'd0);
    s_valid = 1'b0;
    consume();
    chk("pp_rd1", {63'd0, rd_bank}, 64'd1);
    chk("pp_hr1", {63'd0, HASH_ready}, 64'd1);
    consume();
    chk("pp_hr_none", {63'd0, HASH_ready}, 64'd0);
    do_start(1);
    send_word(64'hF4, 1'b1);
    block_done();
    cycle();
    chk("pp_wrap_hr", {63'd0, HASH_ready}, 64'd1);
    chk("pp_wrap_rd", {63'd0, rd_bank}, 64'd0);
    consume();
`endif

    cycle();
    cycle();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
